lcd_capture: RTL and testbench

- Receive end of the parallel RGB/LCD video timing interface: samples hsync/vsync/de and 16-bit pixel data from an upstream timing source or DVP-style camera front end.
- Reconstructs pixel coordinates, measures active frame geometry and reports lock.
- Writes a parameterised IMG_W x IMG_H window of each frame into a frame-buffer RAM through a simple write port.
- Sits between the video input pins/bridge and the image RAM that the display path later reads by linear address.

---
 rtl/lcd_pkg.sv | 25 ++
 rtl/lcd_geom_meas.sv | 60 ++++++
 rtl/lcd_capture.sv | 135 +++++++++++++
 tb/tb_lcd_capture.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared widths, video bus bundle and capture state encoding for the LCD capture path
package lcd_pkg;

  localparam int COORD_W = 11;
  localparam int PIX_W   = 16;

  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [PIX_W-1:0] data;
  } vid_bus_t;

  typedef enum logic {
    ST_SEEK    = 1'b0,
    ST_CAPTURE = 1'b1
  } cap_state_t;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == COORD_MAX) ? v : v + COORD_W'(1);
  endfunction

endpackage

// File: rtl/lcd_geom_meas.sv
// rtl/lcd_geom_meas.sv - pixel/line counters, per-frame geometry measurement and lock tracking
module lcd_geom_meas
  import lcd_pkg::*;
(
  input  logic               clk,
  input  logic               rest,
  input  logic               s1_de,
  input  logic               de_rise,
  input  logic               de_fall,
  input  logic               vs_rise,
  input  logic               frame_end,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] meas_w,
  output logic [COORD_W-1:0] meas_h,
  output logic               locked,
  output logic               geom_err
);

  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [COORD_W-1:0] line_len;
  logic               same_geom;
  logic               zero_geom;

  // x/y describe the pixel sitting in stage 1 right now, so the window test needs no extra delay
  always_comb begin
    x = de_rise ? '0 : sat_inc(x_q);
    y = vs_rise ? '0 : y_q;
  end

  assign same_geom = (line_len == meas_w) && (y_q == meas_h);
  assign zero_geom = (line_len == '0) || (y_q == '0);

  always_ff @(posedge clk) begin
    if (rest) begin
      x_q      <= '0;
      y_q      <= '0;
      line_len <= '0;
      meas_w   <= '0;
      meas_h   <= '0;
      locked   <= 1'b0;
      geom_err <= 1'b0;
    end else begin
      geom_err <= 1'b0;
      if (s1_de) x_q <= x;
      if (vs_rise) y_q <= '0;
      else if (de_fall) y_q <= sat_inc(y_q);
      if (de_fall) line_len <= sat_inc(x_q);
      // pre-clear counters are the geometry of the frame that just ended
      if (frame_end) begin
        meas_w   <= line_len;
        meas_h   <= y_q;
        locked   <= same_geom && !zero_geom;
        geom_err <= locked && !same_geom;
      end
    end
  end

endmodule

// File: rtl/lcd_capture.sv
// rtl/lcd_capture.sv - samples the parallel video bus and writes an IMG_W x IMG_H window into a frame buffer
module lcd_capture
  import lcd_pkg::*;
#(
  parameter int IMG_W  = 200,
  parameter int IMG_H  = 164,
  parameter int IMG_X  = 0,
  parameter int IMG_Y  = 0,
  parameter int ADDR_W = 16
) (
  input  logic               clk,
  input  logic               rest,
  input  logic               vid_hsync,
  input  logic               vid_vsync,
  input  logic               vid_de,
  input  logic [PIX_W-1:0]   vid_data,
  input  logic               capture_en,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PIX_W-1:0]   wr_data,
  output logic               frame_done,
  output logic [COORD_W-1:0] meas_w,
  output logic [COORD_W-1:0] meas_h,
  output logic               locked,
  output logic               geom_err
);

  localparam int X_END = IMG_X + IMG_W;
  localparam int Y_END = IMG_Y + IMG_H;
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  vid_bus_t           s1;
  logic               vs_d;
  logic               de_d;
  logic               vs_rise;
  logic               de_rise;
  logic               de_fall;
  logic               unused_hsync;
  cap_state_t         state;
  cap_state_t         state_nxt;
  logic               frame_end;
  logic               write_ok;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  int                 xi;
  int                 yi;
  logic               row_in_win;
  logic               in_win;
  logic [ADDR_W-1:0]  row_base;

  always_ff @(posedge clk) begin
    if (rest) begin
      s1   <= '0;
      vs_d <= 1'b0;
      de_d <= 1'b0;
    end else begin
      s1   <= '{hsync: vid_hsync, vsync: vid_vsync, de: vid_de, data: vid_data};
      vs_d <= s1.vsync;
      de_d <= s1.de;
    end
  end

  assign vs_rise      = s1.vsync & ~vs_d;
  assign de_rise      = s1.de & ~de_d;
  assign de_fall      = ~s1.de & de_d;
  assign unused_hsync = s1.hsync;

  always_ff @(posedge clk) begin
    if (rest) state <= ST_SEEK;
    else      state <= state_nxt;
  end

  // A pixel coinciding with vs_rise belongs to the new frame, so it follows the next state
  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      ST_SEEK: begin
        if (vs_rise && capture_en) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (vs_rise) begin
          frame_end = 1'b1;
          if (!capture_en) state_nxt = ST_SEEK;
        end
      end
      default: state_nxt = ST_SEEK;
    endcase
    write_ok = (state_nxt == ST_CAPTURE);
  end

  lcd_geom_meas u_geom (
    .clk       (clk),
    .rest      (rest),
    .s1_de     (s1.de),
    .de_rise   (de_rise),
    .de_fall   (de_fall),
    .vs_rise   (vs_rise),
    .frame_end (frame_end),
    .x         (x),
    .y         (y),
    .meas_w    (meas_w),
    .meas_h    (meas_h),
    .locked    (locked),
    .geom_err  (geom_err)
  );

  always_comb begin
    xi         = int'(x);
    yi         = int'(y);
    row_in_win = (yi >= IMG_Y) && (yi < Y_END);
    in_win     = s1.de && row_in_win && (xi >= IMG_X) && (xi < X_END);
  end

  // row_base replaces the (y-IMG_Y)*IMG_W multiply: it steps by IMG_W after each window line
  always_ff @(posedge clk) begin
    if (rest) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      row_base   <= '0;
    end else begin
      wr_en      <= write_ok && in_win;
      frame_done <= frame_end;
      if (write_ok && in_win) begin
        wr_addr <= row_base + ADDR_W'(xi - IMG_X);
        wr_data <= s1.data;
      end
      if (vs_rise) row_base <= '0;
      else if (de_fall && row_in_win) row_base <= row_base + ROW_STEP;
    end
  end

endmodule

// File: tb/tb_lcd_capture.sv
// tb/tb_lcd_capture.sv - randomized frame stream checked against a window/address reference model
module tb_lcd_capture;

  localparam int AW = 16, AH = 12, AX = 0, AY = 0;
  localparam int BW = 20, BH = 40, BX = 30, BY = 2;
  localparam int NW = 40, NH = 30, VB = 4, HB = 8;

  logic        clk = 1'b0;
  logic        rest = 1'b1;
  logic        vid_hsync = 1'b0, vid_vsync = 1'b0, vid_de = 1'b0;
  logic [15:0] vid_data = '0;
  logic        capture_en = 1'b1;

  logic        wr_en_a, frame_done_a, locked_a, geom_err_a;
  logic [15:0] wr_addr_a, wr_data_a;
  logic [10:0] meas_w_a, meas_h_a;
  logic        wr_en_b, frame_done_b, locked_b, geom_err_b;
  logic [15:0] wr_addr_b, wr_data_b;
  logic [10:0] meas_w_b, meas_h_b;

  int checks = 0;
  int fails  = 0;

  logic [31:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
  int fd_a = 0, ge_a = 0;
  int ga0, gb0, fd0, ge0;

  always #5 clk = ~clk;

  lcd_capture #(.IMG_W(AW), .IMG_H(AH), .IMG_X(AX), .IMG_Y(AY), .ADDR_W(16)) dut_a (
    .clk(clk), .rest(rest), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_de(vid_de),
    .vid_data(vid_data), .capture_en(capture_en), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .frame_done(frame_done_a), .meas_w(meas_w_a), .meas_h(meas_h_a),
    .locked(locked_a), .geom_err(geom_err_a)
  );

  lcd_capture #(.IMG_W(BW), .IMG_H(BH), .IMG_X(BX), .IMG_Y(BY), .ADDR_W(16)) dut_b (
    .clk(clk), .rest(rest), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_de(vid_de),
    .vid_data(vid_data), .capture_en(capture_en), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .frame_done(frame_done_b), .meas_w(meas_w_b), .meas_h(meas_h_b),
    .locked(locked_b), .geom_err(geom_err_b)
  );

  always @(negedge clk) begin
    if (wr_en_a) got_a.push_back({wr_addr_a, wr_data_a});
    if (wr_en_b) got_b.push_back({wr_addr_b, wr_data_b});
    if (frame_done_a) fd_a++;
    if (geom_err_a) ge_a++;
  end

  function automatic int diff_a();
    int n = 0;
    for (int i = 0; i < exp_a.size(); i++)
      if (ga0 + i >= got_a.size() || got_a[ga0 + i] !== exp_a[i]) n++;
    return n;
  endfunction

  function automatic int diff_b();
    int n = 0;
    for (int i = 0; i < exp_b.size(); i++)
      if (gb0 + i >= got_b.size() || got_b[gb0 + i] !== exp_b[i]) n++;
    return n;
  endfunction

  task automatic mark();
    ga0 = got_a.size();
    gb0 = got_b.size();
    fd0 = fd_a;
    ge0 = ge_a;
  endtask

  task automatic drive_blank(input int n, input bit vs);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rest      = 1'b0;
      vid_de    = 1'b0;
      vid_vsync = vs;
      vid_hsync = (i < 2);
      vid_data  = 16'($urandom);
    end
  endtask

  // One frame: h active lines of w pixels, then VB blank lines with vsync on lines 1-2.
  // The model pushes every pixel a capturing DUT must write, in raster order.
  task automatic drive_frame(input int w, input int h, input bit cap, input int rst_line,
                             input int rst_x, input int ce_line, input bit ce_val);
    exp_a.delete();
    exp_b.delete();
    for (int y = 0; y < h; y++) begin
      if (y == ce_line) capture_en = ce_val;
      for (int x = 0; x < w; x++) begin
        logic [15:0] d;
        bit live;
        d = 16'($urandom);
        live = cap && !(rst_line >= 0 && (y > rst_line || (y == rst_line && x >= rst_x - 1)));
        if (live && x >= AX && x < AX + AW && y >= AY && y < AY + AH)
          exp_a.push_back({16'((y - AY) * AW + (x - AX)), d});
        if (live && x >= BX && x < BX + BW && y >= BY && y < BY + BH)
          exp_b.push_back({16'((y - BY) * BW + (x - BX)), d});
        @(negedge clk);
        rest      = (y == rst_line) && (x == rst_x);
        vid_de    = 1'b1;
        vid_hsync = 1'b0;
        vid_vsync = 1'b0;
        vid_data  = d;
      end
      drive_blank(int'($urandom_range(HB + 4, HB)), 1'b0);
    end
    for (int l = 0; l < VB; l++) drive_blank(w + HB, (l == 1) || (l == 2));
  endtask

  task automatic test_reset();
    rest = 1'b1;
    repeat (4) begin
      @(negedge clk);
      vid_de    = 1'($urandom);
      vid_vsync = 1'($urandom);
      vid_data  = 16'($urandom);
    end
    @(negedge clk);
    checks++; if (wr_en_a !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", wr_en_a); end
    checks++; if (wr_addr_a !== 16'd0) begin fails++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr_a); end
    checks++; if (wr_data_a !== 16'd0) begin fails++; $display("FAIL reset_wr_data: got %h want 0", wr_data_a); end
    checks++; if (frame_done_a !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b want 0", frame_done_a); end
    checks++; if (meas_w_a !== 11'd0 || meas_h_a !== 11'd0) begin fails++; $display("FAIL reset_meas: got %0dx%0d want 0x0", meas_w_a, meas_h_a); end
    checks++; if (locked_a !== 1'b0 || geom_err_a !== 1'b0) begin fails++; $display("FAIL reset_lock: got locked=%b err=%b want 0/0", locked_a, geom_err_a); end
    checks++; if (wr_en_b !== 1'b0) begin fails++; $display("FAIL reset_wr_en_b: got %b want 0", wr_en_b); end
    vid_de = 1'b0; vid_vsync = 1'b0; vid_data = '0;
    rest = 1'b0;
    drive_blank(5, 1'b0);
  endtask

  task automatic test_capture();
    mark();
    drive_frame(NW, NH, 1'b0, -1, 0, -1, 1'b1);
    checks++; if (got_a.size() - ga0 !== 0 || got_b.size() - gb0 !== 0) begin fails++; $display("FAIL first_frame_no_write: got %0d/%0d writes want 0", got_a.size() - ga0, got_b.size() - gb0); end
    checks++; if (fd_a - fd0 !== 0) begin fails++; $display("FAIL first_frame_done: got %0d pulses want 0", fd_a - fd0); end

    mark();
    drive_frame(NW, NH, 1'b1, -1, 0, -1, 1'b1);
    checks++; if (got_a.size() - ga0 !== AW * AH) begin fails++; $display("FAIL cap_count_a: got %0d want %0d", got_a.size() - ga0, AW * AH); end
    checks++; if (diff_a() !== 0) begin fails++; $display("FAIL cap_data_a: %0d entries differ", diff_a()); end
    checks++; if (got_b.size() - gb0 !== 280) begin fails++; $display("FAIL cap_count_b: got %0d want 280", got_b.size() - gb0); end
    checks++; if (diff_b() !== 0) begin fails++; $display("FAIL cap_data_b: %0d entries differ", diff_b()); end
    if (got_b.size() > gb0 + 10) begin
      checks++; if (got_b[gb0 + 10][31:16] !== 16'd20) begin fails++; $display("FAIL row_stride_b: got %0d want 20", got_b[gb0 + 10][31:16]); end
    end
    checks++; if (fd_a - fd0 !== 1) begin fails++; $display("FAIL cap_frame_done: got %0d want 1", fd_a - fd0); end
    checks++; if (meas_w_a !== 11'(NW) || meas_h_a !== 11'(NH)) begin fails++; $display("FAIL cap_meas: got %0dx%0d want %0dx%0d", meas_w_a, meas_h_a, NW, NH); end
    checks++; if (locked_a !== 1'b0) begin fails++; $display("FAIL cap_not_yet_locked: got %b want 0", locked_a); end

    mark();
    drive_frame(NW, NH, 1'b1, -1, 0, -1, 1'b1);
    checks++; if (diff_a() !== 0 || got_a.size() - ga0 !== exp_a.size()) begin fails++; $display("FAIL cap2_data_a: %0d differ, %0d writes", diff_a(), got_a.size() - ga0); end
    checks++; if (fd_a - fd0 !== 1) begin fails++; $display("FAIL cap2_frame_done: got %0d want 1", fd_a - fd0); end
    checks++; if (locked_a !== 1'b1 || geom_err_a !== 1'b0) begin fails++; $display("FAIL cap2_locked: got %b want 1", locked_a); end
    checks++; if (ge_a - ge0 !== 0) begin fails++; $display("FAIL cap2_no_err: got %0d pulses want 0", ge_a - ge0); end
  endtask

  task automatic test_geom_change();
    mark();
    drive_frame(20, NH, 1'b1, -1, 0, -1, 1'b1);
    checks++; if (ge_a - ge0 !== 1) begin fails++; $display("FAIL geom_err_pulse: got %0d want 1", ge_a - ge0); end
    checks++; if (locked_a !== 1'b0) begin fails++; $display("FAIL geom_unlock: got %b want 0", locked_a); end
    checks++; if (meas_w_a !== 11'd20) begin fails++; $display("FAIL geom_meas_w: got %0d want 20", meas_w_a); end
    checks++; if (diff_a() !== 0 || got_a.size() - ga0 !== AW * AH) begin fails++; $display("FAIL geom_data_a: %0d differ, %0d writes", diff_a(), got_a.size() - ga0); end
    checks++; if (got_b.size() - gb0 !== 0) begin fails++; $display("FAIL geom_outside_b: got %0d writes want 0", got_b.size() - gb0); end

    mark();
    drive_frame(20, NH, 1'b1, -1, 0, -1, 1'b1);
    checks++; if (locked_a !== 1'b1 || ge_a - ge0 !== 0) begin fails++; $display("FAIL geom_relock: got locked=%b errs=%0d want 1/0", locked_a, ge_a - ge0); end

    mark();
    drive_frame(NW, 0, 1'b1, -1, 0, -1, 1'b1);
    checks++; if (locked_a !== 1'b0 || meas_h_a !== 11'd0) begin fails++; $display("FAIL zero_lines: got locked=%b h=%0d want 0/0", locked_a, meas_h_a); end
    checks++; if (ge_a - ge0 !== 1) begin fails++; $display("FAIL zero_lines_err: got %0d want 1", ge_a - ge0); end

    mark();
    drive_frame(NW, NH, 1'b1, -1, 0, -1, 1'b1);
    checks++; if (locked_a !== 1'b0 || ge_a - ge0 !== 0) begin fails++; $display("FAIL after_zero: got locked=%b errs=%0d want 0/0", locked_a, ge_a - ge0); end
    checks++; if (meas_w_a !== 11'(NW) || meas_h_a !== 11'(NH)) begin fails++; $display("FAIL after_zero_meas: got %0dx%0d want %0dx%0d", meas_w_a, meas_h_a, NW, NH); end
  endtask

  task automatic test_reset_mid_frame();
    mark();
    drive_frame(NW, NH, 1'b1, 20, 20, -1, 1'b1);
    checks++; if (got_a.size() - ga0 !== exp_a.size() || diff_a() !== 0) begin fails++; $display("FAIL midrst_a: got %0d writes want %0d", got_a.size() - ga0, exp_a.size()); end
    checks++; if (got_b.size() - gb0 !== 180 || diff_b() !== 0) begin fails++; $display("FAIL midrst_b: got %0d writes want 180", got_b.size() - gb0); end
    checks++; if (fd_a - fd0 !== 0) begin fails++; $display("FAIL midrst_frame_done: got %0d want 0", fd_a - fd0); end
    checks++; if (locked_a !== 1'b0 || meas_w_a !== 11'd0) begin fails++; $display("FAIL midrst_cleared: got locked=%b w=%0d want 0/0", locked_a, meas_w_a); end

    mark();
    drive_frame(NW, NH, 1'b1, -1, 0, -1, 1'b1);
    checks++; if (got_b.size() - gb0 !== 280 || diff_b() !== 0) begin fails++; $display("FAIL midrst_next_b: got %0d writes want 280", got_b.size() - gb0); end
    checks++; if (fd_a - fd0 !== 1 || meas_w_a !== 11'(NW)) begin fails++; $display("FAIL midrst_next_meas: got fd=%0d w=%0d want 1/%0d", fd_a - fd0, meas_w_a, NW); end
  endtask

  task automatic test_capture_en();
    mark();
    drive_frame(NW, NH, 1'b1, -1, 0, 10, 1'b0);
    checks++; if (got_a.size() - ga0 !== AW * AH || diff_a() !== 0) begin fails++; $display("FAIL ce_drop_finish: got %0d writes want %0d", got_a.size() - ga0, AW * AH); end
    checks++; if (fd_a - fd0 !== 1) begin fails++; $display("FAIL ce_drop_done: got %0d want 1", fd_a - fd0); end

    mark();
    drive_frame(NW, NH, 1'b0, -1, 0, -1, 1'b0);
    checks++; if (got_a.size() - ga0 !== 0 || fd_a - fd0 !== 0) begin fails++; $display("FAIL ce_off: got %0d writes %0d done want 0/0", got_a.size() - ga0, fd_a - fd0); end

    mark();
    drive_frame(NW, NH, 1'b0, -1, 0, 5, 1'b1);
    checks++; if (got_a.size() - ga0 !== 0 || got_b.size() - gb0 !== 0) begin fails++; $display("FAIL ce_rise_midframe: got %0d/%0d writes want 0", got_a.size() - ga0, got_b.size() - gb0); end

    mark();
    drive_frame(NW, NH, 1'b1, -1, 0, -1, 1'b1);
    checks++; if (got_a.size() - ga0 !== AW * AH || diff_a() !== 0) begin fails++; $display("FAIL ce_resume_a: got %0d writes want %0d", got_a.size() - ga0, AW * AH); end
    checks++; if (diff_b() !== 0 || got_b.size() - gb0 !== 280) begin fails++; $display("FAIL ce_resume_b: got %0d writes want 280", got_b.size() - gb0); end
    checks++; if (fd_a - fd0 !== 1) begin fails++; $display("FAIL ce_resume_done: got %0d want 1", fd_a - fd0); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_geom_change();
    test_reset_mid_frame();
    test_capture_en();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
